// File: rtl/sample_decimator_if.sv
// ---------------------------------------------------------------------------
// sample_decimator_if
//  Frame streaming bundle between the I2S receiver side and the decimator.
//  Ports / signals:
//   ready_i2s       1-cycle strobe, audio_data_in valid
//   audio_data_in   NUM_CHANNELS*DATA_SIZE input frame (ch0 in LSBs)
//   done            1-cycle strobe, audio_data_out holds a new frame
//   audio_data_out  NUM_CHANNELS*DATA_SIZE output frame, held until next done
//  Modports: master = frame producer / result consumer, slave = decimator.
// ---------------------------------------------------------------------------
interface sample_decimator_if #(
   parameter int DATA_SIZE    = 24,
   parameter int NUM_CHANNELS = 2
);
   logic                              ready_i2s;
   logic [NUM_CHANNELS*DATA_SIZE-1:0] audio_data_in;
   logic                              done;
   logic [NUM_CHANNELS*DATA_SIZE-1:0] audio_data_out;

   modport master (
      output ready_i2s, audio_data_in,
      input  done, audio_data_out
   );

   modport slave (
      input  ready_i2s, audio_data_in,
      output done, audio_data_out
   );
endinterface

// File: rtl/sample_decimator.sv
// ---------------------------------------------------------------------------
// sample_decimator
//  Multi-channel decimator: takes one frame per ready_i2s strobe and emits one
//  frame per 2^shift frames, either the window's last frame (PICK, mode 0) or
//  the per-channel floor average (AVG, mode 1).
//  Ports:
//   clk, rst_n   system clock, async active-low reset
//   enable       0 = idle, partial window discarded, ready_i2s ignored
//   shift_i      log2 decimation factor, values above MAX_SHIFT clamp
//   mode_i       0 = PICK, 1 = AVG
//   busy         1 while a window is partially filled
//   bus          frame strobe/data in, done/data out (slave side)
// ---------------------------------------------------------------------------
module sample_decimator #(
   parameter  int DATA_SIZE    = 24,
   parameter  int NUM_CHANNELS = 2,
   parameter  int MAX_SHIFT    = 4,
   localparam int SHIFT_W      = $clog2(MAX_SHIFT + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [SHIFT_W-1:0] shift_i,
   input  logic               mode_i,
   output logic               busy,
   sample_decimator_if.slave  bus
);

   // Accumulator is wide enough to hold 2^MAX_SHIFT full-scale samples.
   localparam int ACC_W = DATA_SIZE + MAX_SHIFT;
   localparam int CNT_W = (MAX_SHIFT > 0) ? MAX_SHIFT : 1;

   typedef enum logic {IDLE, FILL} state_t;

   state_t                            state, state_nxt;
   logic [CNT_W-1:0]                  counter, counter_nxt;
   logic [CNT_W:0]                    last_idx;
   logic [SHIFT_W-1:0]                cfg_shift, shift_clamped, eff_shift;
   logic                              cfg_mode, eff_mode;
   logic                              opening, take, closing;
   logic signed [ACC_W-1:0]           acc     [NUM_CHANNELS];
   logic signed [ACC_W-1:0]           sum     [NUM_CHANNELS];
   logic signed [ACC_W-1:0]           avg     [NUM_CHANNELS];
   logic signed [DATA_SIZE-1:0]       sample  [NUM_CHANNELS];
   logic [NUM_CHANNELS*DATA_SIZE-1:0] out_nxt;

   // The window's configuration is the live input on the opening strobe and
   // the latched copy for every later strobe of that window.
   always_comb begin
      shift_clamped = (shift_i > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : shift_i;
      opening       = (counter == '0);
      eff_shift     = opening ? shift_clamped : cfg_shift;
      eff_mode      = opening ? mode_i : cfg_mode;
      last_idx      = ((CNT_W + 1)'(1) << eff_shift) - (CNT_W + 1)'(1);
      take          = enable & bus.ready_i2s;
      closing       = take & (counter == last_idx[CNT_W-1:0]);
   end

   // NOTE: every signal assigned in an always_comb gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt   = state;
      counter_nxt = counter;
      if (!enable) begin
         state_nxt   = IDLE;
         counter_nxt = '0;
      end else if (take) begin
         if (closing) begin
            state_nxt   = IDLE;
            counter_nxt = '0;
         end else begin
            state_nxt   = FILL;
            counter_nxt = counter + CNT_W'(1);
         end
      end
   end

   // Per-lane datapath; lanes never interact.
   always_comb begin
      out_nxt = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         sample[c] = signed'(bus.audio_data_in[c*DATA_SIZE +: DATA_SIZE]);
         // First frame of a window loads rather than accumulates.
         sum[c]    = opening ? ACC_W'(sample[c]) : acc[c] + ACC_W'(sample[c]);
         avg[c]    = sum[c] >>> eff_shift;
         out_nxt[c*DATA_SIZE +: DATA_SIZE] = eff_mode ? avg[c][DATA_SIZE-1:0]
                                                      : sample[c];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         counter   <= '0;
         cfg_shift <= '0;
         cfg_mode  <= 1'b0;
      end else begin
         state   <= state_nxt;
         counter <= counter_nxt;
         if (take && opening) begin
            cfg_shift <= shift_clamped;
            cfg_mode  <= mode_i;
         end
      end
   end

   // NOTE: the accumulator array is a handful of flops, not a RAM, so it is
   // reset along with everything else.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CHANNELS; c++) acc[c] <= '0;
      end else if (!enable) begin
         for (int c = 0; c < NUM_CHANNELS; c++) acc[c] <= '0;
      end else if (take) begin
         for (int c = 0; c < NUM_CHANNELS; c++) acc[c] <= sum[c];
      end
   end

   // Output is registered on the closing strobe: done and data appear together
   // exactly one cycle later; data holds until the next close.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.done           <= 1'b0;
         bus.audio_data_out <= '0;
      end else begin
         bus.done <= closing;
         if (closing) bus.audio_data_out <= out_nxt;
      end
   end

   assign busy = (state == FILL);

endmodule

// File: tb/tb_sample_decimator.sv
// ---------------------------------------------------------------------------
// tb_sample_decimator
//  Directed bench for sample_decimator. A window-level model (queue of frames
//  plus floor-division average) predicts done/busy/audio_data_out every cycle;
//  literal checks pin the expected results of the directed scenarios.
// ---------------------------------------------------------------------------
module tb_sample_decimator;

   localparam int DS = 24;
   localparam int NC = 2;
   localparam int MS = 4;
   localparam int SW = $clog2(MS + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic [SW-1:0] shift_i = '0;
   logic          mode_i = 1'b0;
   logic          busy;

   sample_decimator_if #(.DATA_SIZE(DS), .NUM_CHANNELS(NC)) bus ();

   sample_decimator #(.DATA_SIZE(DS), .NUM_CHANNELS(NC), .MAX_SHIFT(MS)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .shift_i (shift_i),
      .mode_i  (mode_i),
      .busy    (busy),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- window-level model ----------------
   logic [NC*DS-1:0] win [$];
   int               m_shift;
   bit               m_mode;
   logic             exp_done;
   logic [NC*DS-1:0] exp_out;

   function automatic logic [NC*DS-1:0] window_result();
      logic [NC*DS-1:0]    r = '0;
      logic signed [DS-1:0] s;
      longint              sum, f, q;
      for (int c = 0; c < NC; c++) begin
         if (!m_mode) begin
            r[c*DS +: DS] = win[win.size()-1][c*DS +: DS];
         end else begin
            sum = 0;
            foreach (win[i]) begin
               s   = win[i][c*DS +: DS];
               sum += longint'(s);
            end
            f = longint'(win.size());
            q = sum / f;
            if ((sum % f != 0) && (sum < 0)) q = q - 1;  // floor, not trunc
            r[c*DS +: DS] = q[DS-1:0];
         end
      end
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win.delete();
         exp_done <= 1'b0;
         exp_out  <= '0;
      end else begin
         exp_done <= 1'b0;
         if (!enable) begin
            win.delete();
         end else if (bus.ready_i2s) begin
            if (win.size() == 0) begin
               m_shift = (int'(shift_i) > MS) ? MS : int'(shift_i);
               m_mode  = mode_i;
            end
            win.push_back(bus.audio_data_in);
            if (win.size() == (1 << m_shift)) begin
               exp_out  <= window_result();
               exp_done <= 1'b1;
               win.delete();
            end
         end
      end
   end

   // Compare process: outputs checked on every falling edge out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         check("cyc_done", {63'd0, bus.done}, {63'd0, exp_done});
         check("cyc_busy", {63'd0, busy}, {63'd0, (win.size() != 0)});
         check("cyc_out", {16'd0, bus.audio_data_out}, {16'd0, exp_out});
      end
   end

   // ---------------- stimulus ----------------
   // Present one frame for one posedge; callers chain sends for back-to-back strobes.
   task automatic send(input logic [DS-1:0] c0, input logic [DS-1:0] c1);
      bus.ready_i2s     = 1'b1;
      bus.audio_data_in = {c1, c0};
      @(negedge clk);
      bus.ready_i2s     = 1'b0;
   endtask

   task automatic lit(input string name, input logic [DS-1:0] c0, input logic [DS-1:0] c1);
      check({name, "_done"}, {63'd0, bus.done}, 64'd1);
      check({name, "_out"}, {16'd0, bus.audio_data_out}, {16'd0, c1, c0});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_done;
      bus.ready_i2s     = 1'b0;
      bus.audio_data_in = '0;
      @(negedge clk);
      check("rst_done", {63'd0, bus.done}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_out", {16'd0, bus.audio_data_out}, 64'd0);
      rst_n  = 1'b1;
      enable = 1'b1;
      @(negedge clk);

      // 1. PICK, factor 4
      mode_i = 1'b0; shift_i = 3'd2;
      send(24'd1, 24'd101); send(24'd2, 24'd102); send(24'd3, 24'd103);
      check("t1_busy", {63'd0, busy}, 64'd1);
      check("t1_nodone", {63'd0, bus.done}, 64'd0);
      send(24'd4, 24'd104);
      lit("t1_a", 24'd4, 24'd104);
      send(24'd5, 24'd0); send(24'd6, 24'd0); send(24'd7, 24'd0); send(24'd8, 24'd9);
      lit("t1_b", 24'd8, 24'd9);
      @(negedge clk);
      check("t1_hold", {16'd0, bus.audio_data_out}, {16'd0, 24'd9, 24'd8});

      // 2. AVG, factor 4, floor on negatives
      mode_i = 1'b1;
      send(24'd10, -24'sd1); send(24'd20, -24'sd2); send(24'd30, -24'sd3); send(24'd41, -24'sd4);
      lit("t2", 24'd25, 24'hFFFFFD);

      // 3. AVG, factor 16, full-scale positive: no wrap
      shift_i = 3'd4;
      for (int i = 0; i < 16; i++) send(24'h7FFFFF, 24'h7FFFFF);
      lit("t3", 24'h7FFFFF, 24'h7FFFFF);

      // 4. factor 1, back-to-back strobes
      shift_i = 3'd0; mode_i = 1'b1; n_done = 0;
      for (int i = 0; i < 5; i++) begin
         send(DS'(i * 7 + 3), -DS'(i + 1));
         if (bus.done) n_done++;
         check("t4_out", {16'd0, bus.audio_data_out}, {16'd0, -DS'(i + 1), DS'(i * 7 + 3)});
      end
      check("t4_ndone", 64'(n_done), 64'd5);
      @(negedge clk);
      check("t4_stop", {63'd0, bus.done}, 64'd0);

      // 5. mid-window shift change takes effect next window
      mode_i = 1'b0; shift_i = 3'd2;
      send(24'd11, 24'd0); send(24'd12, 24'd0);
      shift_i = 3'd1;
      send(24'd13, 24'd0);
      check("t5_nodone", {63'd0, bus.done}, 64'd0);
      send(24'd14, 24'd0);
      lit("t5_a", 24'd14, 24'd0);
      send(24'd15, 24'd0);
      check("t5_nodone2", {63'd0, bus.done}, 64'd0);
      send(24'd16, 24'd0);
      lit("t5_b", 24'd16, 24'd0);

      // 6a. enable drop discards partial window; enable beats a strobe
      mode_i = 1'b1; shift_i = 3'd2;
      send(24'd100, 24'd100); send(24'd100, 24'd100); send(24'd100, 24'd100);
      enable = 1'b0;
      send(24'd100, 24'd100);
      check("t6a_busy", {63'd0, busy}, 64'd0);
      check("t6a_nodone", {63'd0, bus.done}, 64'd0);
      check("t6a_hold", {16'd0, bus.audio_data_out}, {16'd0, 24'd0, 24'd16});
      enable = 1'b1;
      send(24'd4, -24'sd1); send(24'd8, -24'sd1); send(24'd12, -24'sd1); send(24'd16, -24'sd2);
      lit("t6a", 24'd10, 24'hFFFFFE);

      // 6b. async reset mid-window
      send(24'd50, 24'd50); send(24'd50, 24'd50); send(24'd50, 24'd50);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("t6b_busy", {63'd0, busy}, 64'd0);
      check("t6b_out", {16'd0, bus.audio_data_out}, 64'd0);
      send(24'd1, 24'd0); send(24'd2, 24'd0); send(24'd3, 24'd0); send(24'd5, 24'd0);
      lit("t6b", 24'd2, 24'd0);

      // Clamp: shift_i above MAX_SHIFT behaves as factor 16
      mode_i = 1'b0; shift_i = 3'd7;
      for (int i = 1; i <= 15; i++) send(DS'(i), 24'd0);
      check("clamp_nodone", {63'd0, bus.done}, 64'd0);
      send(24'd16, 24'd0);
      lit("clamp", 24'd16, 24'd0);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
